// File: rtl/riscv_decode.sv
// ============================================================================
// riscv_decode : RV32I OP/OP-IMM decode stage, registered output + skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_decode #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             instr_valid,
   input  logic [XLEN-1:0]  instr,
   output logic             instr_ready,
   input  logic             alu_ready,
   output logic             opcodeValid,
   output logic [6:0]       opcode,
   output logic [2:0]       f3,
   output logic [11:0]      imm,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   output logic [4:0]       rd_addr,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam int              FW         = 37;
   localparam logic [6:0]      OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0]      OPC_OP     = 7'b0110011;
   localparam logic [6:0]      F7_ZERO    = 7'b0000000;
   localparam logic [6:0]      F7_ALT     = 7'b0100000;
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [6:0]    dec_op;
   logic [2:0]    dec_f3;
   logic [6:0]    dec_f7;
   logic [11:0]   dec_imm;
   logic [4:0]    dec_rs2;
   logic          dec_legal;
   logic [FW-1:0] dec_fields;
   logic [FW-1:0] out_q;
   logic [FW-1:0] skid_q;
   logic          skid_valid;
   logic          accept;
   logic          drain;

   assign dec_op = instr[6:0];
   assign dec_f3 = instr[14:12];
   assign dec_f7 = instr[31:25];

   always_comb begin
      dec_legal = 1'b0;
      dec_imm   = instr[31:20];
      dec_rs2   = 5'd0;
      case (dec_op)
         OPC_OP_IMM: begin
            case (dec_f3)
               3'b001:  dec_legal = (dec_f7 == F7_ZERO);
               3'b101:  dec_legal = (dec_f7 == F7_ZERO) || (dec_f7 == F7_ALT);
               default: dec_legal = 1'b1;
            endcase
         end
         OPC_OP: begin
            dec_imm   = {dec_f7, 5'b00000};
            dec_rs2   = instr[24:20];
            dec_legal = (dec_f7 == F7_ZERO) ||
                        ((dec_f7 == F7_ALT) && ((dec_f3 == 3'b000) || (dec_f3 == 3'b101)));
         end
         default: dec_legal = 1'b0;
      endcase
   end

   assign dec_fields  = {dec_op, dec_f3, dec_imm, instr[19:15], dec_rs2, instr[11:7]};
   assign instr_ready = ~rst & ~flush & ~skid_valid;
   assign accept      = instr_valid & instr_ready;
   assign drain       = opcodeValid & alu_ready;

   assign {opcode, f3, imm, rs1_addr, rs2_addr, rd_addr} = out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         opcodeValid <= 1'b0;
         out_q       <= '0;
         skid_valid  <= 1'b0;
         skid_q      <= '0;
         illegal     <= 1'b0;
         illegal_cnt <= '0;
      end else if (flush) begin
         opcodeValid <= 1'b0;
         skid_valid  <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         illegal <= accept & ~dec_legal;
         if (accept && !dec_legal && illegal_cnt != CNT_MAX)
            illegal_cnt <= illegal_cnt + CNT_ONE;

         // A full skid blocks acceptance, so only a drain can move it forward.
         if (skid_valid) begin
            if (drain) begin
               out_q      <= skid_q;
               skid_valid <= 1'b0;
            end
         end else if (accept && dec_legal) begin
            if (!opcodeValid || drain) begin
               out_q       <= dec_fields;
               opcodeValid <= 1'b1;
            end else begin
               skid_q     <= dec_fields;
               skid_valid <= 1'b1;
            end
         end else if (drain) begin
            opcodeValid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_riscv_decode.sv
// ============================================================================
// tb_riscv_decode : directed scoreboard bench for riscv_decode
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_decode;

   logic        clk = 1'b0;
   logic        rst, flush, instr_valid, alu_ready;
   logic [31:0] instr;
   logic        instr_ready, opcodeValid, illegal;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [11:0] imm;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [7:0]  illegal_cnt;

   int total = 0;
   int bad   = 0;

   logic [36:0] exp_q[$];
   int          exp_cnt   = 0;
   logic        exp_ill   = 1'b0;
   logic        last_acc  = 1'b0;
   int          stall_left = 0;

   riscv_decode #(.XLEN(32), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .alu_ready(alu_ready), .opcodeValid(opcodeValid),
      .opcode(opcode), .f3(f3), .imm(imm),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [36:0] outs();
      return {opcode, f3, imm, rs1_addr, rs2_addr, rd_addr};
   endfunction

   // Reference decode: bit 37 = legal, bits 36:0 = {op,f3,imm,rs1,rs2,rd}
   function automatic logic [37:0] ref_dec(input logic [31:0] w);
      logic [6:0] op, f7;
      logic [2:0] fn3;
      logic       ok;
      op = w[6:0]; f7 = w[31:25]; fn3 = w[14:12];
      ok = 1'b0;
      if (op == 7'h13) begin
         if (fn3 == 3'd1)      ok = (f7 == 7'h00);
         else if (fn3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
         else                  ok = 1'b1;
         return {ok, op, fn3, w[31:20], w[19:15], 5'd0, w[11:7]};
      end
      if (op == 7'h33) begin
         ok = (f7 == 7'h00) || (f7 == 7'h20 && (fn3 == 3'd0 || fn3 == 3'd5));
         return {ok, op, fn3, f7, 5'd0, w[19:15], w[24:20], w[11:7]};
      end
      return {1'b0, 37'd0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock: pre-edge handshake/scoreboard, post-edge output checks.
   task automatic tick();
      logic [37:0] r;
      #1;
      chk("instr_ready", instr_ready, (!rst && !flush && exp_q.size() < 2));
      if (opcodeValid === 1'b1 && alu_ready) begin
         if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
         else chk("scoreboard", outs(), exp_q.pop_front());
      end
      last_acc = instr_valid && instr_ready;
      exp_ill  = 1'b0;
      if (last_acc) begin
         r = ref_dec(instr);
         if (r[37]) exp_q.push_back(r[36:0]);
         else begin
            exp_ill = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
         end
      end
      if (rst || flush) begin
         exp_q.delete();
         exp_ill = 1'b0;
      end
      if (rst) exp_cnt = 0;
      @(posedge clk);
      #1;
      if (stall_left > 0) stall_left--;
      alu_ready = (stall_left == 0);
      chk("illegal", illegal, exp_ill);
      chk("illegal_cnt", illegal_cnt, exp_cnt);
      chk("opcodeValid", opcodeValid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("out_fields", outs(), exp_q[0]);
   endtask

   task automatic send(input logic [31:0] w);
      int got;
      got = 0;
      instr_valid = 1'b1;
      instr = w;
      for (int i = 0; i < 20 && got == 0; i++) begin
         tick();
         if (last_acc) got = 1;
      end
      chk("accept_timeout", got, 1);
      instr_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      instr_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr = '0; alu_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("reset_valid", opcodeValid, 0);
      chk("reset_fields", outs(), 0);
      chk("reset_ready", instr_ready, 1);

      // Basic decodes with fixed expected values
      send(32'hFFF08293);
      chk("addi", {opcodeValid, outs()}, {1'b1, 7'h13, 3'd0, 12'hFFF, 5'd1, 5'd0, 5'd5});
      send(32'h402081B3);
      chk("sub", {opcodeValid, outs()}, {1'b1, 7'h33, 3'd0, 12'h400, 5'd1, 5'd2, 5'd3});
      send(32'h4020D1B3);
      chk("sra", {opcodeValid, outs()}, {1'b1, 7'h33, 3'd5, 12'h400, 5'd1, 5'd2, 5'd3});
      idle(2);

      // Illegal encodings
      send(32'h00000073);
      chk("ecall_pulse", illegal, 1);
      send(32'h40109093);
      send(32'h022081B3);
      idle(1);
      chk("illegal_cnt_3", illegal_cnt, 3);

      // Back-pressure: ADDI x1..x4 with a three-cycle stall
      stall_left = 3; alu_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send({12'd0, 5'd0, 3'd0, 5'(k), 7'h13});
      idle(4);
      chk("bp_drained", exp_q.size(), 0);

      // Mixed legal/illegal stream at full rate
      for (int k = 0; k < 6; k++) send((k % 2 == 0) ? 32'h00A30313 : 32'h0000006F);

      // Saturate the counter
      idle(1);
      while (exp_cnt < 255) send(32'h00000073);
      idle(1);
      chk("cnt_255", illegal_cnt, 255);
      send(32'h00000073);
      idle(1);
      chk("cnt_sat", illegal_cnt, 255);

      // Flush with both stages full
      stall_left = 1000; alu_ready = 1'b0;
      send(32'h00108093);
      send(32'h00210113);
      flush = 1'b1; instr_valid = 1'b1; instr = 32'h00318193;
      #1;
      chk("ready_in_flush", instr_ready, 0);
      tick();
      flush = 1'b0; instr_valid = 1'b0;
      #1;
      chk("flush_valid", opcodeValid, 0);
      chk("flush_ready", instr_ready, 1);
      chk("flush_cnt", illegal_cnt, 255);

      // Reset mid-stall with both stages full
      send(32'h00108093);
      send(32'h00210113);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      stall_left = 0; alu_ready = 1'b1;
      #1;
      chk("rst_outputs", {opcodeValid, outs(), illegal, illegal_cnt}, 0);
      chk("rst_ready", instr_ready, 1);
      send(32'hFFF08293);
      chk("post_rst_addi", {opcodeValid, outs()}, {1'b1, 7'h13, 3'd0, 12'hFFF, 5'd1, 5'd0, 5'd5});
      idle(3);
      chk("final_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
